cmp_share_arbiter: RTL and testbench
====================================

# cmp_share_arbiter

Sequential controller that shares one 4-bit unsigned magnitude comparator between several requesters. Each requester presents an operand pair and raises a request. The block grants requesters round-robin, registers the winner's operands, runs them through the comparator, and returns a registered greater/less/equal result tagged with the requester index. It sits between the requester ports and the single comparator datapath, which it instantiates internally.

## Interface

- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 4: operand width in bits, unsigned.
- `IDW`, default `$clog2(N_REQ)`: width of the requester index.

- `clk`  in  1  single clock; everything updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level.
- `a_in`  in  N_REQ*W  operand A. Requester i uses bits [i*W +: W].
- `b_in`  in  N_REQ*W  operand B, same packing as `a_in`.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: operands of that requester were captured.
- `done`  out  N_REQ  one-hot, one-cycle pulse: result for that requester is valid.
- `res_gt`  out  1  A > B for the last completed compare.
- `res_lt`  out  1  A < B.
- `res_eq`  out  1  A == B.
- `res_id`  out  IDW  requester index of the last completed compare.
- `busy`  out  1  high while a compare is in flight (state CMP).

## Operation

- States: IDLE, CMP.
- Internal registers:
  - `op_a`, `op_b`: W bits each.
  - `cur_id`: IDW bits.
  - `last_id`: IDW bits, the round-robin pointer.
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise pick the winner: the first set bit of `req`, searching from `last_id+1` upward and wrapping modulo N_REQ.
  - At the edge: `op_a`/`op_b` take the winner's slices, `cur_id` and `last_id` take the winner's index, `gnt[winner]` is set, and the state goes to CMP.
- CMP:
  - The comparator evaluates `op_a`/`op_b`. `req` is ignored.
  - At the edge: `res_gt`/`res_lt`/`res_eq` take the comparator outputs, `res_id` takes `cur_id`, `done[cur_id]` is set, and the state goes to IDLE.
- The comparison is unsigned over W bits. Exactly one of `res_gt`/`res_lt`/`res_eq` is high after the first `done`.
- `res_*` and `res_id` hold their values until the next `done`.
- Request rule: `req` is sampled only in IDLE. A requester must drop `req` by the cycle after it sees `gnt`, or it is treated as a new request.
- Operands need to be stable only in the IDLE cycle in which the grant is decided.
- A requester that is not granted keeps `req` asserted. It is guaranteed service within N_REQ grants.

## Timing

- Reset values:
  - State IDLE.
  - `gnt`, `done`, `busy`, `res_gt`, `res_lt`, `res_eq`, `res_id`: all 0.
  - `op_a`, `op_b`, `cur_id`: 0.
  - `last_id` = N_REQ-1, so requester 0 has first priority.
- Latency: `req` sampled high in IDLE at cycle T gives `gnt` and `busy` high in T+1, and `done` and the result in T+2.
- Throughput: one compare per 2 cycles. A new grant can be decided in cycle T+2, the same cycle `done` is high.
- `gnt` and `busy` are high in the same cycle. `done` is never high in the same cycle as `busy`.
- Wrap-around: after granting index N_REQ-1, the search starts at 0.
- Simultaneous requests: only one grant per decision. The others wait.
- Reset asserted in CMP aborts the compare: no `done`, the result registers clear, and the pointer returns to N_REQ-1.
- Reset asserted in the same cycle as an IDLE grant decision: no `gnt` in the next cycle.

## Test plan

- Single requester: `req`=0001, a0=2, b0=3. Expect `gnt`=0001 at T+1, `done`=0001 at T+2, lt=1, gt=0, eq=0, `res_id`=0.
- Values across slots: slot1 a=5 b=3 gives gt=1; slot2 a=3 b=3 gives eq=1; slot3 a=15 b=0 gives gt=1 (unsigned check); slot0 a=2 b=10 gives lt=1.
- All four requesters raise `req`=1111 after reset, each dropping after its `gnt`. Expect grants in order 0, 1, 2, 3, with `gnt` pulses 2 cycles apart and each `res_id` matching.
- Fairness and wrap: `req`[0] and `req`[3] held high continuously. Expect grant order 0, 3, 0, 3, … Neither requester is granted twice in a row.
- Reset mid-operation: assert `rst` in the CMP cycle. Expect no `done` pulse, all outputs 0 in the next cycle, and the next grant going to the lowest-index requester.
- Back-to-back: `req`[1] is re-raised in the `done` cycle. Expect the next `gnt` exactly 2 cycles after the previous `gnt`.

Source files
------------

// File: rtl/cmp_share_arbiter_if.sv
// Requester-side bus of the shared comparator arbiter.
//   req      : per-requester request level
//   a_in     : packed operand A, requester i at [i*W +: W]
//   b_in     : packed operand B, same packing
//   gnt      : one-hot pulse, operands of that requester captured
//   done     : one-hot pulse, result for that requester valid
//   res_gt/lt/eq : registered comparison result of the last completed compare
//   res_id   : requester index of the last completed compare
//   busy     : a compare is in flight
// master = requester side, slave = arbiter side.
interface cmp_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_in;
    logic [N_REQ*W-1:0] b_in;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic               res_gt;
    logic               res_lt;
    logic               res_eq;
    logic [IDW-1:0]     res_id;
    logic               busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, res_gt, res_lt, res_eq, res_id, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, res_gt, res_lt, res_eq, res_id, busy
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Shares one unsigned magnitude comparator between N_REQ requesters.
// Requests are granted round-robin; the winner's operands are registered,
// compared in the following cycle, and a tagged result is returned.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : cmp_share_arbiter_if.slave (req/a_in/b_in in, gnt/done/res_*/busy out)

// Unsigned W-bit magnitude comparator, purely combinational.
module cmp_mag #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         lt,
    output logic         eq
);
    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

// state | meaning
// IDLE  | waiting for a request; grant decided combinationally, taken at the edge
// CMP   | captured operands on the comparator; result registered at the edge
module cmp_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    cmp_share_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CMP} state_t;

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           state;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [IDW-1:0]   cur_id;
    logic [IDW-1:0]   last_id;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic             res_gt_q;
    logic             res_lt_q;
    logic             res_eq_q;
    logic [IDW-1:0]   res_id_q;
    logic             busy_q;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   cand;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;

    // Search starts one past the last winner so the last winner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_id) + k) % N_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    cmp_mag #(.W(W)) u_cmp (
        .a  (op_a),
        .b  (op_b),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            cur_id   <= '0;
            last_id  <= IDW'(N_REQ - 1);
            gnt_q    <= '0;
            done_q   <= '0;
            res_gt_q <= 1'b0;
            res_lt_q <= 1'b0;
            res_eq_q <= 1'b0;
            res_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_a    <= bus.a_in[int'(win_id)*W +: W];
                        op_b    <= bus.b_in[int'(win_id)*W +: W];
                        cur_id  <= win_id;
                        last_id <= win_id;
                        gnt_q   <= ONE_HOT0 << win_id;
                        busy_q  <= 1'b1;
                        state   <= CMP;
                    end
                end
                CMP: begin
                    res_gt_q <= cmp_gt;
                    res_lt_q <= cmp_lt;
                    res_eq_q <= cmp_eq;
                    res_id_q <= cur_id;
                    done_q   <= ONE_HOT0 << cur_id;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.res_gt = res_gt_q;
    assign bus.res_lt = res_lt_q;
    assign bus.res_eq = res_eq_q;
    assign bus.res_id = res_id_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
module tb_cmp_share_arbiter;
    localparam int N = 4;
    localparam int W = 4;

    typedef struct {
        logic [N-1:0] oh;
        int           cyc;
    } gexp_t;

    typedef struct {
        int         id;
        logic [2:0] f;     // {gt, lt, eq}
        int         cyc;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ge;
    rexp_t re;
    logic [N-1:0] done_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cmp_share_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    cmp_share_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Monitor: pops expectations whenever the DUT presents gnt or done.
    always @(negedge clk) begin
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL gnt_missing: got no gnt, required gnt=%b at cycle %0d", gq[0].oh, gq[0].cyc);
            ge = gq.pop_front();
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL done_missing: got no done, required id=%0d at cycle %0d", rq[0].id, rq[0].cyc);
            re = rq.pop_front();
        end
        if (bus.gnt !== '0) begin
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL gnt_unexpected: got gnt=%b at cycle %0d, required none", bus.gnt, cyc);
            end else begin
                ge = gq.pop_front();
                if (bus.gnt !== ge.oh || cyc != ge.cyc || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gnt: got gnt=%b cyc=%0d busy=%b, required gnt=%b cyc=%0d busy=1",
                             bus.gnt, cyc, bus.busy, ge.oh, ge.cyc);
                end
            end
        end
        if (bus.done !== '0) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done=%b at cycle %0d, required none", bus.done, cyc);
            end else begin
                re = rq.pop_front();
                done_exp = {{(N-1){1'b0}}, 1'b1} << re.id;
                if (bus.done !== done_exp || cyc != re.cyc || bus.busy !== 1'b0 ||
                    bus.res_id !== 2'(re.id) ||
                    {bus.res_gt, bus.res_lt, bus.res_eq} !== re.f) begin
                    errors++;
                    $display("FAIL done: got done=%b id=%0d gle=%b cyc=%0d busy=%b, required done=%b id=%0d gle=%b cyc=%0d busy=0",
                             bus.done, bus.res_id, {bus.res_gt, bus.res_lt, bus.res_eq}, cyc, bus.busy,
                             done_exp, re.id, re.f, re.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_ops(input int s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a_in[s*W +: W] = a;
        bus.b_in[s*W +: W] = b;
    endtask

    task automatic exp_gnt(input int s, input int c);
        gexp_t g;
        logic [N-1:0] one;
        one   = {{(N-1){1'b0}}, 1'b1};
        g.oh  = one << s;
        g.cyc = c;
        gq.push_back(g);
    endtask

    task automatic exp_res(input int s, input logic [2:0] f, input int c);
        rexp_t r;
        r.id  = s;
        r.f   = f;
        r.cyc = c;
        rq.push_back(r);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.gnt !== '0 || bus.done !== '0 || bus.busy !== 1'b0 || bus.res_gt !== 1'b0 ||
            bus.res_lt !== 1'b0 || bus.res_eq !== 1'b0 || bus.res_id !== '0) begin
            errors++;
            $display("FAIL %s: got gnt=%b done=%b busy=%b gle=%b id=%0d, required all zero",
                     name, bus.gnt, bus.done, bus.busy, {bus.res_gt, bus.res_lt, bus.res_eq}, bus.res_id);
        end
    endtask

    task automatic drain(input string name);
        tick(); tick(); tick();
        #1;
        checks++;
        if (gq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d gnt and %0d done outstanding, required 0", name, gq.size(), rq.size());
        end
    endtask

    task automatic single_op(input int s, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        int c;
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        set_ops(s, a, b);
        bus.req = one << s;
        c = cyc;
        exp_gnt(s, c + 1);
        exp_res(s, f, c + 2);
        tick();
        bus.req = '0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        logic [2:0] f4[4];
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        rst = 1'b1;
        tick(); tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("idle_no_req");

        // Single requester, then one value per slot (15 vs 0 is the unsigned case).
        single_op(0, 4'd2, 4'd3, 3'b010);
        single_op(1, 4'd5, 4'd3, 3'b100);
        single_op(2, 4'd3, 4'd3, 3'b001);
        single_op(3, 4'd15, 4'd0, 3'b100);
        single_op(0, 4'd2, 4'd10, 3'b010);
        drain("slots");

        // All four request together after reset, each drops after its grant.
        do_reset();
        set_ops(0, 4'd1, 4'd1);
        set_ops(1, 4'd0, 4'd15);
        set_ops(2, 4'd9, 4'd8);
        set_ops(3, 4'd7, 4'd7);
        f4 = '{3'b001, 3'b010, 3'b100, 3'b001};
        c = cyc;
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_gnt(i, c + 1 + 2*i);
            exp_res(i, f4[i], c + 2 + 2*i);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.req[i] = 1'b0;
            tick();
        end
        drain("all_four");

        // Requesters 0 and 3 held high: alternate 0, 3, 0, 3 ...
        set_ops(0, 4'd4, 4'd6);
        set_ops(3, 4'd8, 4'd2);
        c = cyc;
        bus.req = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            exp_gnt((k % 2 == 0) ? 0 : 3, c + 1 + 2*k);
            exp_res((k % 2 == 0) ? 0 : 3, (k % 2 == 0) ? 3'b010 : 3'b100, c + 2 + 2*k);
        end
        repeat (15) tick();
        bus.req = '0;
        drain("fair");

        // Reset during CMP: no done, outputs cleared, pointer back to N-1.
        set_ops(2, 4'd3, 4'd12);
        c = cyc;
        bus.req = 4'b0100;
        exp_gnt(2, c + 1);
        tick();
        rst = 1'b1;
        bus.req = '0;
        tick();
        check_zero("abort");
        rst = 1'b0;
        set_ops(1, 4'd6, 4'd1);
        set_ops(3, 4'd0, 4'd0);
        c = cyc;
        bus.req = 4'b1010;
        exp_gnt(1, c + 1);
        exp_res(1, 3'b100, c + 2);
        exp_gnt(3, c + 3);
        exp_res(3, 3'b001, c + 4);
        tick();
        bus.req = 4'b1000;
        tick(); tick();
        bus.req = '0;
        drain("after_abort");

        // Reset in the same cycle as a grant decision: no grant follows.
        set_ops(0, 4'd1, 4'd2);
        bus.req = 4'b0001;
        rst = 1'b1;
        tick();
        check_zero("reset_at_decision");
        bus.req = '0;
        rst = 1'b0;
        drain("reset_at_decision");

        // Back-to-back: requester 1 re-raises in its done cycle.
        set_ops(1, 4'd6, 4'd6);
        c = cyc;
        bus.req = 4'b0010;
        exp_gnt(1, c + 1);
        exp_res(1, 3'b001, c + 2);
        tick();
        bus.req = '0;
        tick();
        set_ops(1, 4'd14, 4'd13);
        bus.req = 4'b0010;
        exp_gnt(1, c + 3);
        exp_res(1, 3'b100, c + 4);
        tick();
        bus.req = '0;
        drain("back_to_back");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
